// File: rtl/codec_serial_if.sv
// Serial codec interface: BCLK/LRCK generation, left-justified mono ADC capture and DAC playback.
// Build option: define VOLUME_SCALE_EN to attenuate the DAC word by volume_control at tx load.
module codec_serial_if #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned SLOT_BITS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        codec_bclk,
  output logic        codec_lrck,
  output logic        codec_dacdat,
  input  logic        codec_adcdat,
  output logic [15:0] adc_sample,
  output logic        sample_end,
  input  logic [15:0] dac_sample,
  output logic        sample_req,
  input  logic [3:0]  volume_control
);

  localparam int unsigned DivW = $clog2(CLK_DIV);
  localparam int unsigned BitW = $clog2(SLOT_BITS);

  typedef enum logic [0:0] {StLeft, StRight} slot_e;

  // Divider and bit clock
  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic            bclk_q;
  logic            div_tc;
  logic            rise_evt;
  logic            fall_evt;

  // Bit counter and slot FSM
  logic [BitW-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]      bit_q_ext;
  logic [7:0]      bit_d_ext;
  logic            bit_wrap;
  slot_e           state_q, state_d;
  logic            lrck;
  logic            enter_left;

  // TX path
  logic            req_dly_q;
  logic [15:0]     dac_latch_q;
  logic [15:0]     tx_reg_q;
  logic [15:0]     tx_load;
  logic [15:0]     tx_src;
  logic            tx_bit;
  logic            dacdat_q;
  logic            sample_req_q;
  logic            req_hit;

  // RX path
  logic [15:0]     rx_reg_q;
  logic [15:0]     rx_shift;
  logic            rx_en;
  logic            capture;
  logic [15:0]     adc_sample_q;
  logic            end_pend_q;
  logic            sample_end_q;

  assign div_tc   = (div_cnt_q == DivW'(CLK_DIV - 1));
  assign rise_evt = div_tc & ~bclk_q;
  assign fall_evt = div_tc & bclk_q;

  always_comb begin
    div_cnt_d = div_cnt_q + DivW'(1);
    if (div_tc) begin
      div_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      if (div_tc) begin
        bclk_q <= ~bclk_q;
      end
    end
  end

  assign bit_wrap  = (bit_cnt_q == BitW'(SLOT_BITS - 1));
  assign bit_q_ext = 8'(bit_cnt_q);
  assign bit_d_ext = 8'(bit_cnt_d);

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    if (fall_evt) begin
      bit_cnt_d = bit_wrap ? '0 : bit_cnt_q + BitW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // Slot FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StLeft;
    end else begin
      state_q <= state_d;
    end
  end

  // Slot FSM: next state, slots swap on the fall event that wraps the bit counter
  always_comb begin
    state_d = state_q;
    if (fall_evt && bit_wrap) begin
      unique case (state_q)
        StLeft:  state_d = StRight;
        StRight: state_d = StLeft;
        default: state_d = StLeft;
      endcase
    end
  end

  // Slot FSM: outputs
  always_comb begin
    lrck = 1'b1;
    unique case (state_q)
      StLeft:  lrck = 1'b1;
      StRight: lrck = 1'b0;
      default: lrck = 1'b1;
    endcase
  end

  assign enter_left = fall_evt & bit_wrap & (state_q == StRight);

`ifdef VOLUME_SCALE_EN
  assign tx_load = 16'($signed(dac_latch_q) >>> (4'd15 - volume_control));
`else
  logic unused_volume;
  assign unused_volume = ^volume_control;
  assign tx_load       = dac_latch_q;
`endif

  // Bit for the slot position being entered; the same word is sent in both slots
  assign tx_src = enter_left ? tx_load : tx_reg_q;

  always_comb begin
    tx_bit = 1'b0;
    if (bit_d_ext < 8'd16) begin
      tx_bit = tx_src[4'd15 - bit_cnt_d[3:0]];
    end
  end

  assign req_hit = fall_evt & (state_q == StRight) & (bit_cnt_q == BitW'(SLOT_BITS - 2));

  // dac_sample is latched two clocks after the request to absorb the consumer's register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_dly_q    <= 1'b0;
      dac_latch_q  <= '0;
      tx_reg_q     <= '0;
      dacdat_q     <= 1'b0;
      sample_req_q <= 1'b0;
    end else begin
      req_dly_q    <= sample_req_q;
      sample_req_q <= req_hit;
      if (req_dly_q) begin
        dac_latch_q <= dac_sample;
      end
      if (fall_evt) begin
        dacdat_q <= tx_bit;
        if (enter_left) begin
          tx_reg_q <= tx_load;
        end
      end
    end
  end

  assign rx_shift = {rx_reg_q[14:0], codec_adcdat};
  assign rx_en    = rise_evt & (state_q == StLeft) & (bit_q_ext <= 8'd15);
  assign capture  = rx_en & (bit_q_ext == 8'd15);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_reg_q     <= '0;
      adc_sample_q <= '0;
      end_pend_q   <= 1'b0;
      sample_end_q <= 1'b0;
    end else begin
      end_pend_q   <= capture;
      sample_end_q <= end_pend_q;
      if (rx_en) begin
        rx_reg_q <= rx_shift;
      end
      if (capture) begin
        adc_sample_q <= rx_shift;
      end
    end
  end

  assign codec_bclk   = bclk_q;
  assign codec_lrck   = lrck;
  assign codec_dacdat = dacdat_q;
  assign adc_sample   = adc_sample_q;
  assign sample_end   = sample_end_q;
  assign sample_req   = sample_req_q;

  a_strobe_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(sample_req_q && sample_end_q));
  a_req_width: assert property (@(posedge clk) disable iff (!rst_n)
    sample_req_q |=> !sample_req_q);
  a_end_width: assert property (@(posedge clk) disable iff (!rst_n)
    sample_end_q |=> !sample_end_q);

endmodule
